// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter: shares one slave data/sync/ready channel between NUM_REQ
// requesters. A winner's data is captured once per grant and held on s_out with
// s_out_sync high until the slave samples s_ready high.
// Arbitration is round-robin by default; define ARB_FIXED_PRIO_EN for fixed
// priority (lowest valid index wins, no round-robin pointer).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/req_data  per-requester valid and packed data (lane i at i*DATA_W)
//   req_grant           one-cycle pulse marking the captured requester
//   s_out/s_out_sync    data and valid toward the slave
//   s_ready             slave accepts s_out
//   owner               index of the current or last granted requester
//   busy                high while a transfer is pending at the slave
module slave_port_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [DATA_W-1:0]          s_out,
    output logic                       s_out_sync,
    input  logic                       s_ready,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        SEC_IDLE = 1'b0,
        SEC_SEND = 1'b1
    } section_t;

    section_t             state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0]    s_out_q, s_out_d;
    logic                 sync_q, sync_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 busy_q, busy_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    logic [DATA_W-1:0]    lane_data [NUM_REQ];
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    // Unpack the flat requester data bus into lanes
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane_data[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Winner select: first valid index, scanning from rr_ptr (or from 0)
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
`endif
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        grant_d  = '0;
        s_out_d  = s_out_q;
        sync_d   = sync_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            SEC_IDLE: begin
                if (win_found) begin
                    s_out_d = lane_data[win_idx];
                    owner_d = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    sync_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEC_SEND;
                end
            end
            SEC_SEND: begin
                if (s_ready) begin
                    sync_d   = 1'b0;
                    busy_d   = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_d = IDX_W'((32'(owner_q) + 32'd1) % NUM_REQ);
`endif
                    state_d  = SEC_IDLE;
                end
            end
            default: state_d = SEC_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SEC_IDLE;
            grant_q  <= '0;
            s_out_q  <= '0;
            sync_q   <= 1'b0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            s_out_q  <= s_out_d;
            sync_q   <= sync_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign req_grant  = grant_q;
    assign s_out      = s_out_q;
    assign s_out_sync = sync_q;
    assign owner      = owner_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Scoreboard bench for slave_port_arbiter: expected grants are queued when
// stimulus is applied and compared when the DUT pulses req_grant.
module tb_slave_port_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_grant;
    logic [DATA_W-1:0]         s_out;
    logic                      s_out_sync;
    logic                      s_ready = 1'b0;
    logic [IDX_W-1:0]          owner;
    logic                      busy;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    slave_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_grant  (req_grant),
        .s_out      (s_out),
        .s_out_sync (s_out_sync),
        .s_ready    (s_ready),
        .owner      (owner),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue an expected grant for requester idx with its current lane data
    task automatic push_exp(input int unsigned idx);
        exp_t e;
        e.idx  = IDX_W'(idx);
        e.data = req_data[idx*DATA_W +: DATA_W];
        sb_q.push_back(e);
    endtask

    // Grant monitor: every grant pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst && req_grant != '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_grant", 64'(req_grant), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("grant",      64'(req_grant),  64'(NUM_REQ'(1) << mon_e.idx));
                check("owner",      64'(owner),      64'(mon_e.idx));
                check("s_out",      64'(s_out),      64'(mon_e.data));
                check("sync_grant", 64'(s_out_sync), 64'd1);
                check("busy_grant", 64'(busy),       64'd1);
            end
        end
    end

    task automatic wait_grant(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (req_grant == '0 && lat < 10);
        if (req_grant == '0) check("grant_timeout", 64'd0, 64'd1);
    endtask

    // One transfer: request, expect grant next cycle, hold for 'hold' cycles
    task automatic xfer(input logic [NUM_REQ-1:0] valid, input int unsigned exp_idx,
                        input int unsigned hold);
        int lat;
        logic [DATA_W-1:0] exp_data;
        logic [NUM_REQ*DATA_W-1:0] saved;
        push_exp(exp_idx);
        exp_data  = req_data[exp_idx*DATA_W +: DATA_W];
        s_ready   = (hold == 0);
        req_valid = valid;
        wait_grant(lat);
        check("latency", 64'(lat), 64'd1);
        req_valid = '0;
        if (hold > 0) begin
            saved     = req_data;
            req_data  = ~req_data;
            req_valid = '1;
            for (int i = 0; i < int'(hold); i++) begin
                @(negedge clk);
                check("hold_sync",  64'(s_out_sync), 64'd1);
                check("hold_data",  64'(s_out),      64'(exp_data));
                check("hold_owner", 64'(owner),      64'(exp_idx));
                check("hold_grant", 64'(req_grant),  64'd0);
                check("hold_busy",  64'(busy),       64'd1);
            end
            req_valid = '0;
            req_data  = saved;
            s_ready   = 1'b1;
        end
        @(negedge clk);
        check("done_sync",  64'(s_out_sync), 64'd0);
        check("done_busy",  64'(busy),       64'd0);
        check("done_grant", 64'(req_grant),  64'd0);
        check("keep_data",  64'(s_out),      64'(exp_data));
        // s_ready while idle must not produce anything
        @(negedge clk);
        check("idle_sync", 64'(s_out_sync), 64'd0);
        s_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int grants;
        int last;
        int unsigned rr_seq [5];
        req_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_00F0};

        // Reset with all requesters valid: everything stays zero
        req_valid = '1;
        s_ready   = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", 64'(req_grant),  64'd0);
        check("rst_sout",  64'(s_out),      64'd0);
        check("rst_sync",  64'(s_out_sync), 64'd0);
        check("rst_owner", 64'(owner),      64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        rst = 1'b1;
        xfer(4'b1111, 0, 0);

        // Backpressure on requester 1 with data 7
        req_data[1*DATA_W +: DATA_W] = 32'h7;
        xfer(4'b0010, 1, 5);

        // Single requester 2 with data A5
        req_data[2*DATA_W +: DATA_W] = 32'hA5;
        xfer(4'b0100, 2, 0);

        // Wrap/skip: pointer at 3, requesters 0 and 1 valid
        xfer(4'b0011, 0, 0);
`ifdef ARB_FIXED_PRIO_EN
        xfer(4'b0011, 0, 0);
`else
        xfer(4'b0011, 1, 0);
`endif

        // Reset in the middle of a held transfer
        s_ready   = 1'b0;
        req_valid = 4'b0100;
        push_exp(2);
        wait_grant(lat);
        req_valid = '0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_sync",  64'(s_out_sync), 64'd0);
        check("mid_rst_busy",  64'(busy),       64'd0);
        check("mid_rst_owner", 64'(owner),      64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("no_replay_sync",  64'(s_out_sync), 64'd0);
        check("no_replay_grant", 64'(req_grant),  64'd0);

        // All requesters valid continuously with slave always ready
`ifdef ARB_FIXED_PRIO_EN
        rr_seq = '{0, 0, 0, 0, 0};
`else
        rr_seq = '{0, 1, 2, 3, 0};
`endif
        foreach (rr_seq[i]) push_exp(rr_seq[i]);
        s_ready   = 1'b1;
        req_valid = '1;
        grants    = 0;
        last      = 0;
        for (int n = 0; n < 30 && grants < 5; n++) begin
            @(negedge clk);
            if (req_grant != '0) begin
                grants++;
                if (grants > 1) check("rr_spacing", 64'(cyc - last), 64'd2);
                last = cyc;
                if (grants == 5) req_valid = '0;
            end
        end
        req_valid = '0;
        check("rr_grants", 64'(grants), 64'd5);
        repeat (3) @(negedge clk);
        check("rr_end_sync", 64'(s_out_sync), 64'd0);
        check("sb_empty",    64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
